scandoubler_timing: RTL and testbench

- Sequencer for the line-doubling scandoubler datapath.
- Measures the incoming line length and hsync width in input pixels.
- Generates the write address (hcnt), the read address at the doubled rate (sd_hcnt), the line-buffer bank select (line_toggle), and the doubled hsync/vsync.
- Sits between the video source and the scandoubler line-buffer/scanline block. It drives the buffer's framing inputs and hs_sd.

---
 rtl/scandoubler_timing.sv | 109 ++++++++++
 tb/tb_scandoubler_timing.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler_timing.sv
// Line-doubling scandoubler sequencer: measures input line and hsync
// length, drives buffer write/read addresses, bank select and 2x syncs.
module scandoubler_timing #(
   parameter int HCNT_WIDTH  = 10,
   parameter int HSCNT_WIDTH = 12
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  pe_in,
   input  logic                  pe_out,
   input  logic                  hs_in,
   input  logic                  vs_in,
   output logic [HCNT_WIDTH-1:0] hcnt,
   output logic [HCNT_WIDTH-1:0] sd_hcnt,
   output logic                  line_toggle,
   output logic                  hs_sd,
   output logic                  vs_sd,
   output logic [HCNT_WIDTH-1:0] line_len,
   output logic                  locked,
   output logic                  overflow
);

   localparam int CW = (HCNT_WIDTH > HSCNT_WIDTH) ? HCNT_WIDTH : HSCNT_WIDTH;
   localparam logic [HCNT_WIDTH-1:0] HMAX = '1;

   logic                   hs_d;
   logic [HSCNT_WIDTH-1:0] hs_width;
   logic [HSCNT_WIDTH-1:0] hs_len;
   logic                   pending;

   logic                   rise;
   logic                   fall;
   logic                   hcnt_max;
   logic [HCNT_WIDTH-1:0]  len_next;
   logic                   len_match;
   logic                   sd_wrap;
   logic                   hs_hit;

   // Edge detect, saturated length and output-side decode terms.
   always_comb begin
      rise      = hs_in & ~hs_d;
      fall      = hs_d & ~hs_in;
      hcnt_max  = (hcnt == HMAX);
      len_next  = hcnt_max ? HMAX : hcnt + 1'b1;
      len_match = (len_next == line_len) && (line_len != '0) && !hcnt_max;
      sd_wrap   = (line_len != '0) && (sd_hcnt == line_len - 1'b1);
      hs_hit    = (hs_len != '0) && (CW'(sd_hcnt) < CW'(hs_len));
   end

   // Input side: write address, line measurement and lock tracking.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hs_d        <= 1'b0;
         hcnt        <= '0;
         line_toggle <= 1'b0;
         line_len    <= '0;
         overflow    <= 1'b0;
         locked      <= 1'b0;
         hs_width    <= '0;
         hs_len      <= '0;
      end else if (pe_in) begin
         hs_d <= hs_in;
         if (rise) begin
            hcnt        <= '0;
            line_toggle <= ~line_toggle;
            line_len    <= len_next;
            overflow    <= hcnt_max;
            locked      <= len_match;
            hs_width    <= HSCNT_WIDTH'(1);
         end else begin
            if (!hcnt_max)
               hcnt <= hcnt + 1'b1;
            if (hs_in && (hs_width != '1))
               hs_width <= hs_width + 1'b1;
            if (fall)
               hs_len <= hs_width;
         end
      end
   end

   // Line-start handoff: set by an input rise, consumed by the next pe_out.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         pending <= 1'b0;
      else if (pe_in && rise)
         pending <= 1'b1;
      else if (pe_out && pending)
         pending <= 1'b0;
   end

   // Output side: doubled-rate read address and retimed syncs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sd_hcnt <= '0;
         hs_sd   <= 1'b0;
         vs_sd   <= 1'b0;
      end else if (pe_out) begin
         if (pending)
            sd_hcnt <= '0;
         else if (sd_wrap)
            sd_hcnt <= '0;
         else
            sd_hcnt <= sd_hcnt + 1'b1;
         hs_sd <= hs_hit;
         vs_sd <= vs_in;
      end
   end

endmodule

// File: tb/tb_scandoubler_timing.sv
// Scoreboard bench for scandoubler_timing: randomized video stream
// against an integer reference model of the line timing rules.
module tb_scandoubler_timing;

   localparam int MAXV  = 1023;
   localparam int HSMAX = 4095;

   logic       clk_sys;
   logic       reset_n;
   logic       pe_in;
   logic       pe_out;
   logic       hs_in;
   logic       vs_in;
   logic [9:0] hcnt;
   logic [9:0] sd_hcnt;
   logic       line_toggle;
   logic       hs_sd;
   logic       vs_sd;
   logic [9:0] line_len;
   logic       locked;
   logic       overflow;

   scandoubler_timing dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .pe_in       (pe_in),
      .pe_out      (pe_out),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .hcnt        (hcnt),
      .sd_hcnt     (sd_hcnt),
      .line_toggle (line_toggle),
      .hs_sd       (hs_sd),
      .vs_sd       (vs_sd),
      .line_len    (line_len),
      .locked      (locked),
      .overflow    (overflow)
   );

   typedef struct {
      int hcnt;
      int sd;
      int lt;
      int hs;
      int vs;
      int len;
      int lk;
      int ov;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic vs_cur = 1'b0;

   // reference model state (plain integers, pixel count unbounded)
   int m_pix, m_hsd, m_hsw, m_hslen, m_pend;
   int m_sd, m_lt, m_hssd, m_vssd, m_len, m_lk, m_ov;

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_reset();
      m_pix = 0; m_hsd = 0; m_hsw = 0; m_hslen = 0; m_pend = 0;
      m_sd = 0; m_lt = 0; m_hssd = 0; m_vssd = 0;
      m_len = 0; m_lk = 0; m_ov = 0;
   endfunction

   function automatic exp_t snap();
      exp_t s;
      s.hcnt = imin(m_pix, MAXV);
      s.sd   = m_sd;
      s.lt   = m_lt;
      s.hs   = m_hssd;
      s.vs   = m_vssd;
      s.len  = m_len;
      s.lk   = m_lk;
      s.ov   = m_ov;
      return s;
   endfunction

   // One clock of the timing rules; output side sees pre-edge values.
   function automatic void model_step(input int pi, input int po,
                                      input int hs, input int vs);
      int len;
      int ovf;
      if (po != 0) begin
         m_hssd = (m_hslen != 0 && m_sd < m_hslen) ? 1 : 0;
         if (m_pend != 0) begin
            m_sd   = 0;
            m_pend = 0;
         end else if (m_len != 0 && m_sd == m_len - 1)
            m_sd = 0;
         else
            m_sd = (m_sd + 1) % (MAXV + 1);
         m_vssd = vs;
      end
      if (pi != 0) begin
         if (hs != 0 && m_hsd == 0) begin
            len    = imin(m_pix + 1, MAXV);
            ovf    = (m_pix >= MAXV) ? 1 : 0;
            m_lk   = (ovf == 0 && len == m_len && m_len != 0) ? 1 : 0;
            m_len  = len;
            m_ov   = ovf;
            m_lt   = 1 - m_lt;
            m_pix  = 0;
            m_hsw  = 1;
            m_pend = 1;
         end else begin
            m_pix++;
            if (hs != 0)
               m_hsw++;
            else if (m_hsd != 0)
               m_hslen = imin(m_hsw, HSMAX);
         end
         m_hsd = hs;
      end
   endfunction

   task automatic step(input logic pi, input logic po,
                       input logic hs, input logic vs);
      @(negedge clk_sys);
      reset_n = 1'b1;
      pe_in   = pi;
      pe_out  = po;
      hs_in   = hs;
      vs_in   = vs;
      model_step(int'(pi), int'(po), int'(hs), int'(vs));
      q.push_back(snap());
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         reset_n = 1'b0;
         model_reset();
         q.push_back(snap());
         if (i == 0) begin
            #1;
            chk("rst_hcnt", int'(hcnt), 0);
            chk("rst_sd_hcnt", int'(sd_hcnt), 0);
            chk("rst_toggle", int'(line_toggle), 0);
            chk("rst_hs_sd", int'(hs_sd), 0);
            chk("rst_vs_sd", int'(vs_sd), 0);
            chk("rst_line_len", int'(line_len), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_overflow", int'(overflow), 0);
         end
      end
   endtask

   // pin_div/pout_div of 0 means random enables
   task automatic run_lines(input int len, input int w, input int pin_div,
                            input int pout_div, input int nlines,
                            input int reset_at);
      int p = 0;
      int tot = 0;
      int cyc = 0;
      int lines = 0;
      logic pi;
      logic po;
      while (lines < nlines) begin
         pi = (pin_div == 0) ? ($urandom_range(0, 2) == 0)
                             : ((cyc % pin_div) == 0);
         po = (pout_div == 0) ? ($urandom_range(0, 1) == 1)
                              : ((cyc % pout_div) == 0);
         if ($urandom_range(0, 15) == 0)
            vs_cur = ~vs_cur;
         step(pi, po, (p < w), vs_cur);
         if (pi) begin
            p++;
            tot++;
            if (p == len) begin
               p = 0;
               lines++;
            end
            if (tot == reset_at)
               do_reset(2);
         end
         cyc++;
      end
   endtask

   task automatic settle();
      step(1'b0, 1'b0, hs_in, vs_in);
      @(posedge clk_sys);
      #2;
   endtask

   // monitor: compare DUT against the queued expectation after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_sys);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("hcnt", int'(hcnt), e.hcnt);
            chk("sd_hcnt", int'(sd_hcnt), e.sd);
            chk("line_toggle", int'(line_toggle), e.lt);
            chk("hs_sd", int'(hs_sd), e.hs);
            chk("vs_sd", int'(vs_sd), e.vs);
            chk("line_len", int'(line_len), e.len);
            chk("locked", int'(locked), e.lk);
            chk("overflow", int'(overflow), e.ov);
         end
      end
   end

   initial begin
      int l;
      reset_n = 1'b0;
      pe_in   = 1'b0;
      pe_out  = 1'b0;
      hs_in   = 1'b0;
      vs_in   = 1'b0;
      model_reset();
      do_reset(3);

      run_lines(200, 20, 4, 2, 4, -1);
      settle();
      chk("steady_len", int'(line_len), 200);
      chk("steady_locked", int'(locked), 1);

      run_lines(201, 20, 4, 2, 2, -1);
      settle();
      chk("change_len", int'(line_len), 201);
      chk("change_unlocked", int'(locked), 0);
      run_lines(201, 20, 4, 2, 1, -1);
      settle();
      chk("change_relocked", int'(locked), 1);

      for (int k = 0; k < 3; k++) begin
         l = $urandom_range(30, 120);
         run_lines(l, $urandom_range(1, l - 1), 0, 0, 3,
                   (k == 1) ? 77 : -1);
      end

      run_lines(1100, 30, 1, 1, 2, -1);
      settle();
      chk("ovf_len", int'(line_len), MAXV);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_locked", int'(locked), 0);

      run_lines(1500, 0, 1, 2, 1, -1);
      settle();
      chk("nohs_hcnt", int'(hcnt), MAXV);

      run_lines(50, 5, 1, 1, 4, -1);
      l = $urandom_range(30, 120);
      run_lines(l, $urandom_range(1, l - 1), 0, 0, 3, 40);
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
